spi_burst_sequencer: RTL and testbench
======================================

# spi_burst_sequencer

Byte-level command sequencer between the SPI shift-register slave and the 224×8 configuration memory. It decodes an opcode/address header at the start of each chip-select frame. It then generates auto-incrementing memory addresses and write strobes for burst writes and burst reads, and flags malformed frames. It runs entirely in the SCLK domain and replaces per-byte address handling in the control path.

## Interface
- DEPTH, 224, number of memory bytes; valid addresses 0..DEPTH-1
- ADDR_W, 8, memory address width
- SCLK  in  1  SPI clock; all state updates on rising edge
- RESET  in  1  asynchronous, active-high; clock SCLK
- SS  in  1  chip select, active low; high = frame inactive
- data_valid  in  1  one-SCLK pulse from slave: rx_byte complete
- rx_byte  in  8  received byte, valid while data_valid=1
- mem_addr  out  ADDR_W  memory address (registered)
- mem_we  out  1  memory write strobe (combinational)
- mem_wdata  out  8  write data, equals rx_byte
- busy  out  1  FSM not in IDLE
- err_flag  out  1  sticky frame-error flag
- byte_count  out  16  bytes written since reset (only with BURST_COUNT_EN)

## Operation
- Opcodes: 0x01 WRITE, 0x03 READ, 0x06 CLR_ERR; any other opcode is an error.
- Frame format: opcode byte, then (WRITE/READ only) one address byte, then any number of data bytes.
- FSM states and transitions, all taken only on data_valid=1 while SS=0:
  - IDLE: 0x01 → WADDR; 0x03 → RADDR; 0x06 → clear err_flag, stay IDLE; other opcode → set err_flag, go to DISCARD.
  - WADDR / RADDR: if rx_byte < DEPTH, load mem_addr ← rx_byte and go to WDATA / RDATA; otherwise set err_flag and go to DISCARD.
  - WDATA: write the byte to mem[mem_addr], then advance mem_addr.
  - RDATA: advance mem_addr on each byte.
  - DISCARD: ignore all bytes until the frame ends.
- Address advance: mem_addr ← (mem_addr == DEPTH-1) ? 0 : mem_addr+1. Wrap-around is legal and not an error.
- mem_we = data_valid & (state==WDATA) & ~SS. mem_wdata = rx_byte.
- SS high asynchronously forces the FSM to IDLE. mem_addr, err_flag and byte_count are retained.
- data_valid while SS=1 is ignored.
- A frame that ends inside WADDR or RADDR (no address byte received) is not an error.
- Reset values: state IDLE, mem_addr 0, mem_we 0, busy 0, err_flag 0, byte_count 0.

## Timing
- Write: zero latency. mem_we is high in the same SCLK cycle as the data_valid pulse, and memory captures at that rising edge. mem_addr updates at the same edge, so it is valid for the next byte.
- Read: the new mem_addr is visible one cycle after the address byte's data_valid edge. The memory read data must be stable before the slave loads its next transmit byte.
- Read: each RDATA data_valid advances mem_addr one cycle later, which prefetches the next byte.
- Back-to-back data_valid pulses are supported, one byte per pulse.
- RESET asserted mid-burst: immediate return to reset values, and no further write.
- CLR_ERR and a new error in the same frame cannot coincide; CLR_ERR is a single-byte frame.

## Configuration
- BURST_COUNT_EN defined: byte_count port exists.
  - 16-bit counter increments on each mem_we.
  - Saturates at 0xFFFF.
  - Cleared only by RESET.
- Undefined: byte_count port and counter are absent; all other behaviour is identical.

## Structure
- Shared package holds:
  - opcode constants OP_WRITE=8'h01, OP_READ=8'h03, OP_CLR_ERR=8'h06;
  - FSM state encoding (IDLE, WADDR, WDATA, RADDR, RDATA, DISCARD);
  - DEPTH default 224.
- One natural sub-module: spi_addr_counter. It is the loadable wrap-around address register with load, inc and DEPTH parameter, and it is reused by the read and write paths.

## Test plan
- Write burst: SS low, bytes 0x01,0x10,0xAA,0xBB,0xCC → mem_we pulses on the three data bytes at addresses 0x10,0x11,0x12; final mem_addr=0x13; err_flag=0.
- Wrap: 0x01,0xDF,0x11,0x22 → writes at 223 then 0; mem_addr=1.
- Read: 0x03,0x05 then three dummy bytes → mem_addr 0x05,0x06,0x07,0x08 in sequence; mem_we never high.
- Errors and clear:
  - opcode 0x42 → err_flag=1 and busy=1 until SS rises; following bytes cause no mem_we.
  - 0x01,0xE0 → err_flag=1.
  - frame 0x06 → err_flag=0.
- Abort: SS rises after 0x01,0x20,0x55 → IDLE immediately; the next frame 0x03,0x00 works normally; address 0x20 was written once.
- Reset/count (BURST_COUNT_EN): RESET pulse during WDATA → all outputs return to reset values and byte_count=0; five bytes written afterwards → byte_count=5.

Source files
------------

// File: rtl/spi_burst_sequencer_pkg.sv
// Shared definitions for the SPI burst sequencer: opcodes, FSM state encoding and the
// default memory depth.
package spi_burst_sequencer_pkg;

    parameter int unsigned DefaultDepth = 224;

    localparam logic [7:0] OP_WRITE   = 8'h01;
    localparam logic [7:0] OP_READ    = 8'h03;
    localparam logic [7:0] OP_CLR_ERR = 8'h06;

    typedef enum logic [2:0] {
        StIdle,
        StWaddr,
        StWdata,
        StRaddr,
        StRdata,
        StDiscard
    } state_e;

endpackage

// File: rtl/spi_addr_counter.sv
// Loadable address register that wraps from DEPTH-1 back to 0; shared by the read and
// write paths of the burst sequencer.
module spi_addr_counter #(
    parameter int unsigned DEPTH  = 224,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              SCLK,
    input  logic              RESET,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] addr_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load_i) begin
            addr_d = load_val_i;
        end else if (inc_i) begin
            addr_d = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge SCLK or posedge RESET) begin
        if (RESET) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/spi_burst_sequencer.sv
// Decodes the opcode/address header of each SPI frame and drives burst memory accesses.
// Define BURST_COUNT_EN to add the saturating byte_count output of bytes written.
module spi_burst_sequencer
    import spi_burst_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH  = DefaultDepth,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              SCLK,
    input  logic              RESET,
    input  logic              SS,
    input  logic              data_valid,
    input  logic [7:0]        rx_byte,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              err_flag
`ifdef BURST_COUNT_EN
    ,
    output logic [15:0]       byte_count
`endif
);

    state_e state_q, state_d;
    logic   err_q, err_d;
    logic   addr_load, addr_inc;
    logic   fire;

    assign fire = data_valid & ~SS;

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        addr_load = 1'b0;
        addr_inc  = 1'b0;
        mem_we    = 1'b0;
        if (fire) begin
            case (state_q)
                StIdle: begin
                    if (rx_byte == OP_WRITE) begin
                        state_d = StWaddr;
                    end else if (rx_byte == OP_READ) begin
                        state_d = StRaddr;
                    end else if (rx_byte == OP_CLR_ERR) begin
                        err_d = 1'b0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StDiscard;
                    end
                end
                StWaddr, StRaddr: begin
                    if (32'(rx_byte) < DEPTH) begin
                        addr_load = 1'b1;
                        state_d   = (state_q == StWaddr) ? StWdata : StRdata;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StDiscard;
                    end
                end
                StWdata: begin
                    mem_we   = 1'b1;
                    addr_inc = 1'b1;
                end
                StRdata: begin
                    addr_inc = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Raising SS aborts the frame at once; address and error state survive.
    always_ff @(posedge SCLK or posedge RESET or posedge SS) begin
        if (RESET || SS) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge SCLK or posedge RESET) begin
        if (RESET) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    spi_addr_counter #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_addr_counter (
        .SCLK       (SCLK),
        .RESET      (RESET),
        .load_i     (addr_load),
        .load_val_i (ADDR_W'(rx_byte)),
        .inc_i      (addr_inc),
        .addr_o     (mem_addr)
    );

`ifdef BURST_COUNT_EN
    logic [15:0] count_q;

    always_ff @(posedge SCLK or posedge RESET) begin
        if (RESET) begin
            count_q <= '0;
        end else if (mem_we && count_q != 16'hFFFF) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign byte_count = count_q;
`endif

    assign mem_wdata = rx_byte;
    assign busy      = (state_q != StIdle);
    assign err_flag  = err_q;

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Directed self-checking bench for spi_burst_sequencer with hand-computed expectations.
module tb_spi_burst_sequencer;

    logic       SCLK = 1'b0;
    logic       RESET = 1'b1;
    logic       SS = 1'b1;
    logic       data_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic       busy;
    logic       err_flag;
`ifdef BURST_COUNT_EN
    logic [15:0] byte_count;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    always #5 SCLK = ~SCLK;

    spi_burst_sequencer dut (
        .SCLK       (SCLK),
        .RESET      (RESET),
        .SS         (SS),
        .data_valid (data_valid),
        .rx_byte    (rx_byte),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .err_flag   (err_flag)
`ifdef BURST_COUNT_EN
        ,
        .byte_count (byte_count)
`endif
    );

    // Drive one byte pulse; report pre-edge strobe, address and write data.
    task automatic send(input logic [7:0] b, output logic we, output logic [7:0] addr,
                        output logic [7:0] wd);
        @(negedge SCLK);
        data_valid = 1'b1;
        rx_byte    = b;
        #1;
        we   = mem_we;
        addr = mem_addr;
        wd   = mem_wdata;
    endtask

    task automatic idle();
        @(negedge SCLK);
        data_valid = 1'b0;
        #1;
    endtask

    task automatic ss_low();
        @(negedge SCLK);
        data_valid = 1'b0;
        SS = 1'b0;
    endtask

    // Raise SS away from any clock edge and check the FSM drops out immediately.
    task automatic ss_high(input string name);
        @(negedge SCLK);
        data_valid = 1'b0;
        #2 SS = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy after SS rise: got %b want 0", name, busy);
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp += 4;
        if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL reset mem_addr: got %h want 00", mem_addr); end
        if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset mem_we: got %b want 0", mem_we); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
        if (err_flag !== 1'b0) begin n_fail++; $display("FAIL reset err_flag: got %b want 0", err_flag); end
        @(negedge SCLK);
        RESET = 1'b0;
    endtask

    task automatic test_write_burst();
        logic [7:0] bytes [5] = '{8'h01, 8'h10, 8'hAA, 8'hBB, 8'hCC};
        logic [7:0] addrs [5] = '{8'h00, 8'h00, 8'h10, 8'h11, 8'h12};
        logic we;
        logic [7:0] a, wd;
        ss_low();
        for (int i = 0; i < 5; i++) begin
            send(bytes[i], we, a, wd);
            n_cmp++;
            if (we !== (i >= 2)) begin
                n_fail++;
                $display("FAIL write mem_we byte %0d: got %b want %b", i, we, (i >= 2));
            end
            if (i >= 2) begin
                n_cmp += 2;
                if (a !== addrs[i]) begin n_fail++; $display("FAIL write addr byte %0d: got %h want %h", i, a, addrs[i]); end
                if (wd !== bytes[i]) begin n_fail++; $display("FAIL write wdata byte %0d: got %h want %h", i, wd, bytes[i]); end
            end
        end
        idle();
        n_cmp += 3;
        if (mem_addr !== 8'h13) begin n_fail++; $display("FAIL write final addr: got %h want 13", mem_addr); end
        if (err_flag !== 1'b0) begin n_fail++; $display("FAIL write err_flag: got %b want 0", err_flag); end
        if (busy !== 1'b1) begin n_fail++; $display("FAIL write busy: got %b want 1", busy); end
        ss_high("write");
    endtask

    task automatic test_wrap();
        logic we;
        logic [7:0] a, wd;
        ss_low();
        send(8'h01, we, a, wd);
        send(8'hDF, we, a, wd);
        send(8'h11, we, a, wd);
        n_cmp++;
        if (we !== 1'b1 || a !== 8'hDF) begin n_fail++; $display("FAIL wrap first write: got we=%b addr=%h want we=1 addr=df", we, a); end
        send(8'h22, we, a, wd);
        n_cmp++;
        if (we !== 1'b1 || a !== 8'h00) begin n_fail++; $display("FAIL wrap second write: got we=%b addr=%h want we=1 addr=00", we, a); end
        idle();
        n_cmp += 2;
        if (mem_addr !== 8'h01) begin n_fail++; $display("FAIL wrap final addr: got %h want 01", mem_addr); end
        if (err_flag !== 1'b0) begin n_fail++; $display("FAIL wrap err_flag: got %b want 0", err_flag); end
        ss_high("wrap");
    endtask

    task automatic test_read();
        logic we;
        logic [7:0] a, wd;
        logic any_we = 1'b0;
        ss_low();
        send(8'h03, we, a, wd);
        any_we |= we;
        send(8'h05, we, a, wd);
        any_we |= we;
        for (int i = 0; i < 3; i++) begin
            send(8'hFF, we, a, wd);
            any_we |= we;
            n_cmp++;
            if (a !== 8'(8'h05 + i)) begin
                n_fail++;
                $display("FAIL read addr dummy %0d: got %h want %h", i, a, 8'(8'h05 + i));
            end
        end
        idle();
        n_cmp += 2;
        if (mem_addr !== 8'h08) begin n_fail++; $display("FAIL read final addr: got %h want 08", mem_addr); end
        if (any_we !== 1'b0) begin n_fail++; $display("FAIL read mem_we seen: got %b want 0", any_we); end
        ss_high("read");
    endtask

    task automatic test_errors();
        logic we;
        logic [7:0] a, wd;
        logic any_we = 1'b0;
        ss_low();
        send(8'h42, we, a, wd);
        idle();
        n_cmp += 2;
        if (err_flag !== 1'b1) begin n_fail++; $display("FAIL badop err_flag: got %b want 1", err_flag); end
        if (busy !== 1'b1) begin n_fail++; $display("FAIL badop busy: got %b want 1", busy); end
        send(8'h01, we, a, wd); any_we |= we;
        send(8'h10, we, a, wd); any_we |= we;
        send(8'hAA, we, a, wd); any_we |= we;
        n_cmp++;
        if (any_we !== 1'b0) begin n_fail++; $display("FAIL discard mem_we: got %b want 0", any_we); end
        ss_high("badop");
        n_cmp++;
        if (err_flag !== 1'b1) begin n_fail++; $display("FAIL err sticky after SS: got %b want 1", err_flag); end
        ss_low();
        send(8'h06, we, a, wd);
        idle();
        n_cmp += 2;
        if (err_flag !== 1'b0) begin n_fail++; $display("FAIL clr_err err_flag: got %b want 0", err_flag); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_err busy: got %b want 0", busy); end
        ss_high("clr1");
        ss_low();
        send(8'h01, we, a, wd);
        send(8'hE0, we, a, wd);
        send(8'hAA, we, a, wd);
        n_cmp += 2;
        if (we !== 1'b0) begin n_fail++; $display("FAIL badaddr mem_we: got %b want 0", we); end
        if (err_flag !== 1'b1) begin n_fail++; $display("FAIL badaddr err_flag: got %b want 1", err_flag); end
        ss_high("badaddr");
        ss_low();
        send(8'h06, we, a, wd);
        idle();
        n_cmp++;
        if (err_flag !== 1'b0) begin n_fail++; $display("FAIL clr_err2 err_flag: got %b want 0", err_flag); end
        ss_high("clr2");
    endtask

    task automatic test_abort();
        logic we;
        logic [7:0] a, wd;
        int writes_20 = 0;
        ss_low();
        send(8'h01, we, a, wd);
        send(8'h20, we, a, wd);
        send(8'h55, we, a, wd);
        if (we && a == 8'h20) writes_20++;
        ss_high("abort");
        // Inputs pulsed while deselected must be ignored.
        send(8'h01, we, a, wd);
        if (we && a == 8'h20) writes_20++;
        idle();
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ss_high ignore busy: got %b want 0", busy); end
        ss_low();
        send(8'h03, we, a, wd);
        send(8'h00, we, a, wd);
        send(8'hFF, we, a, wd);
        if (we && a == 8'h20) writes_20++;
        n_cmp += 2;
        if (a !== 8'h00) begin n_fail++; $display("FAIL abort next read addr: got %h want 00", a); end
        if (writes_20 !== 1) begin n_fail++; $display("FAIL abort writes to 20: got %0d want 1", writes_20); end
        idle();
        n_cmp++;
        if (mem_addr !== 8'h01) begin n_fail++; $display("FAIL abort read advance: got %h want 01", mem_addr); end
        ss_high("abort2");
    endtask

    task automatic test_reset_mid_burst();
        logic we;
        logic [7:0] a, wd;
        ss_low();
        send(8'h01, we, a, wd);
        send(8'h30, we, a, wd);
        send(8'h77, we, a, wd);
        @(negedge SCLK);
        rx_byte = 8'h88;
        #1 RESET = 1'b1;
        #1;
        n_cmp += 4;
        if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst mid mem_we: got %b want 0", mem_we); end
        if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL rst mid mem_addr: got %h want 00", mem_addr); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst mid busy: got %b want 0", busy); end
        if (err_flag !== 1'b0) begin n_fail++; $display("FAIL rst mid err_flag: got %b want 0", err_flag); end
`ifdef BURST_COUNT_EN
        n_cmp++;
        if (byte_count !== 16'd0) begin n_fail++; $display("FAIL rst mid byte_count: got %0d want 0", byte_count); end
`endif
        @(negedge SCLK);
        data_valid = 1'b0;
        RESET = 1'b0;
        send(8'h01, we, a, wd);
        send(8'h40, we, a, wd);
        for (int i = 0; i < 5; i++) send(8'(i), we, a, wd);
        idle();
        n_cmp++;
        if (mem_addr !== 8'h45) begin n_fail++; $display("FAIL post-reset burst addr: got %h want 45", mem_addr); end
`ifdef BURST_COUNT_EN
        n_cmp++;
        if (byte_count !== 16'd5) begin n_fail++; $display("FAIL byte_count: got %0d want 5", byte_count); end
`endif
        ss_high("rst");
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_wrap();
        test_read();
        test_errors();
        test_abort();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
